// File: rtl/v_ctx_admit.sv
// v_ctx_admit: per-context admission stage in front of `v`.
// Counts outstanding entries per context, admits a command only when its
// context has room, and presents admitted commands through a one-deep
// registered valid/ready output stage. Releases from `v` free entries.
// Optional build macro: V_CTX_ADMIT_REL_BYPASS_EN lets a same-cycle release
// unblock a full context (adds a rel_* -> in_rdy combinational path).
module v_ctx_admit #(
  parameter int CONTEXT_N = 128,
  parameter int ENTRIES_N = 4,
  parameter int DATA_W    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_vld,
  input  logic [$clog2(CONTEXT_N)-1:0]           in_ctx,
  input  logic [DATA_W-1:0]                      in_data,
  output logic                                   in_rdy,
  output logic                                   out_vld,
  output logic [$clog2(CONTEXT_N)-1:0]           out_ctx,
  output logic [DATA_W-1:0]                      out_data,
  input  logic                                   out_rdy,
  input  logic                                   rel_vld,
  input  logic [$clog2(CONTEXT_N)-1:0]           rel_ctx,
  output logic [$clog2(CONTEXT_N*ENTRIES_N+1)-1:0] busy_cnt,
  output logic                                   err_underflow
);

  localparam int CTX_W = $clog2(CONTEXT_N);
  localparam int CNT_W = $clog2(ENTRIES_N + 1);
  localparam int BSY_W = $clog2(CONTEXT_N * ENTRIES_N + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENTRIES_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BSY_W-1:0] BSY_ONE  = BSY_W'(1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [CONTEXT_N];
  logic [CTX_W-1:0]  ctx_p0;
  logic [DATA_W-1:0] data_p0;

  logic in_cnt_full;
  logic rel_cnt_zero;
  logic ctx_free;
  logic admit;
  logic rel_ok;

  assign in_cnt_full  = (cnt_q[in_ctx] == CNT_FULL);
  assign rel_cnt_zero = (cnt_q[rel_ctx] == '0);

`ifdef V_CTX_ADMIT_REL_BYPASS_EN
  // A release arriving for the same context frees a slot this very cycle.
  assign ctx_free = !in_cnt_full ||
                    (rel_vld && (rel_ctx == in_ctx) && (cnt_q[in_ctx] != '0));
`else
  assign ctx_free = !in_cnt_full;
`endif

  assign out_vld  = (state_q == FULL);
  assign in_rdy   = (!out_vld || out_rdy) && ctx_free;
  assign admit    = in_vld && in_rdy;
  assign rel_ok   = rel_vld && !rel_cnt_zero;
  assign out_ctx  = ctx_p0;
  assign out_data = data_p0;

  // Output stage next-state: fill on admit, drain on handshake without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (admit) state_d = FULL;
      FULL:  if (out_rdy && !admit) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // ---- stage p0: capture admitted command, held while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_p0  <= '0;
      data_p0 <= '0;
    end else if (admit) begin
      ctx_p0  <= in_ctx;
      data_p0 <= in_data;
    end
  end

  // Per-context occupancy: charge at admit, free on non-underflow release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CONTEXT_N; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CONTEXT_N; c++) begin
        if (admit && (in_ctx == CTX_W'(c)) &&
            !(rel_ok && (rel_ctx == CTX_W'(c))))
          cnt_q[c] <= cnt_q[c] + CNT_ONE;
        else if (rel_ok && (rel_ctx == CTX_W'(c)) &&
                 !(admit && (in_ctx == CTX_W'(c))))
          cnt_q[c] <= cnt_q[c] - CNT_ONE;
      end
    end
  end

  // Aggregate occupancy, tracked alongside the per-context counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= '0;
    else if (admit && !rel_ok) busy_cnt <= busy_cnt + BSY_ONE;
    else if (rel_ok && !admit) busy_cnt <= busy_cnt - BSY_ONE;
  end

  // Sticky underflow flag on release to an empty context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_underflow <= 1'b0;
    else if (rel_vld && rel_cnt_zero) err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_v_ctx_admit.sv
// Directed bench for v_ctx_admit with immediate-assertion checks.
module tb_v_ctx_admit;

  localparam int CONTEXT_N = 128;
  localparam int ENTRIES_N = 4;
  localparam int DATA_W    = 32;
  localparam int CTX_W     = $clog2(CONTEXT_N);
  localparam int BSY_W     = $clog2(CONTEXT_N * ENTRIES_N + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld;
  logic [CTX_W-1:0]  in_ctx;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              out_vld;
  logic [CTX_W-1:0]  out_ctx;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  logic              rel_vld;
  logic [CTX_W-1:0]  rel_ctx;
  logic [BSY_W-1:0]  busy_cnt;
  logic              err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  v_ctx_admit #(.CONTEXT_N(CONTEXT_N), .ENTRIES_N(ENTRIES_N), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_ctx(in_ctx), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_ctx(out_ctx), .out_data(out_data), .out_rdy(out_rdy),
    .rel_vld(rel_vld), .rel_ctx(rel_ctx),
    .busy_cnt(busy_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_ctx = '0; in_data = '0;
    out_rdy = 1'b0; rel_vld = 1'b0; rel_ctx = '0;
    step(); step();
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_ctx", 32'(out_ctx), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    rst = 1'b0;
    #1 chk("rst_in_rdy", 32'(in_rdy), 32'd1);

    // four commands to ctx 5, each emerging one cycle later
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_ctx = 7'd5; in_data = 32'hA0 + 32'(i);
      #1 chk("fill_in_rdy", 32'(in_rdy), 32'd1);
      step();
      chk("fill_out_vld", 32'(out_vld), 32'd1);
      chk("fill_out_data", out_data, 32'hA0 + 32'(i));
      chk("fill_out_ctx", 32'(out_ctx), 32'd5);
    end
    chk("cnt5_full", 32'(dut.cnt_q[5]), 32'd4);
    chk("busy_4", 32'(busy_cnt), 32'd4);
    in_data = 32'hA4;
    #1 chk("ctx5_blocked", 32'(in_rdy), 32'd0);
    in_ctx = 7'd6; in_data = 32'hB6;
    #1 chk("ctx6_open", 32'(in_rdy), 32'd1);
    step();
    chk("ctx6_out_data", out_data, 32'hB6);
    chk("ctx6_out_ctx", 32'(out_ctx), 32'd6);
    chk("busy_5", 32'(busy_cnt), 32'd5);
    chk("cnt6", 32'(dut.cnt_q[6]), 32'd1);

    // stall: output held stable for 10 cycles
    out_rdy = 1'b0; in_ctx = 7'd7; in_data = 32'hC7;
    #1 chk("stall_in_rdy", 32'(in_rdy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_out_vld", 32'(out_vld), 32'd1);
      chk("stall_out_data", out_data, 32'hB6);
      chk("stall_in_rdy_hold", 32'(in_rdy), 32'd0);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    step();
    chk("drain_out_vld", 32'(out_vld), 32'd0);
    chk("drain_busy", 32'(busy_cnt), 32'd5);

    // release and admit to full ctx 5 in the same cycle
    rel_vld = 1'b1; rel_ctx = 7'd5;
    in_vld = 1'b1; in_ctx = 7'd5; in_data = 32'hD5;
`ifdef V_CTX_ADMIT_REL_BYPASS_EN
    #1 chk("byp_in_rdy", 32'(in_rdy), 32'd1);
    step();
    rel_vld = 1'b0;
    chk("byp_cnt5", 32'(dut.cnt_q[5]), 32'd4);
    chk("byp_busy", 32'(busy_cnt), 32'd5);
    chk("byp_out_data", out_data, 32'hD5);
`else
    #1 chk("nobyp_in_rdy", 32'(in_rdy), 32'd0);
    step();
    rel_vld = 1'b0;
    chk("nobyp_cnt5_rel", 32'(dut.cnt_q[5]), 32'd3);
    chk("nobyp_busy_rel", 32'(busy_cnt), 32'd4);
    chk("nobyp_out_vld", 32'(out_vld), 32'd0);
    #1 chk("nobyp_in_rdy_next", 32'(in_rdy), 32'd1);
    step();
    chk("nobyp_cnt5", 32'(dut.cnt_q[5]), 32'd4);
    chk("nobyp_busy", 32'(busy_cnt), 32'd5);
    chk("nobyp_out_data", out_data, 32'hD5);
`endif
    in_vld = 1'b0;
    step();
    chk("rel_drain", 32'(out_vld), 32'd0);

    // underflow release to empty ctx 9
    rel_vld = 1'b1; rel_ctx = 7'd9;
    step();
    rel_vld = 1'b0;
    chk("uf_cnt9", 32'(dut.cnt_q[9]), 32'd0);
    chk("uf_busy", 32'(busy_cnt), 32'd5);
    chk("uf_err", 32'(err_underflow), 32'd1);
    step(); step(); step();
    chk("uf_err_sticky", 32'(err_underflow), 32'd1);

    // ctx 127 to 2 entries, then admit ctx 0 with release of ctx 127
    in_vld = 1'b1; in_ctx = 7'd127; in_data = 32'hE0;
    step();
    in_data = 32'hE1;
    step();
    chk("c127_cnt", 32'(dut.cnt_q[127]), 32'd2);
    chk("busy_7", 32'(busy_cnt), 32'd7);
    in_ctx = 7'd0; in_data = 32'hF0;
    rel_vld = 1'b1; rel_ctx = 7'd127;
    step();
    in_vld = 1'b0; rel_vld = 1'b0; out_rdy = 1'b0;
    chk("mix_cnt0", 32'(dut.cnt_q[0]), 32'd1);
    chk("mix_cnt127", 32'(dut.cnt_q[127]), 32'd1);
    chk("mix_busy", 32'(busy_cnt), 32'd7);
    chk("mix_out_data", out_data, 32'hF0);
    step();
    chk("pre_rst_out_vld", 32'(out_vld), 32'd1);

    // asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_busy", 32'(busy_cnt), 32'd0);
    chk("arst_err", 32'(err_underflow), 32'd0);
    chk("arst_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    chk("arst_cnt5", 32'(dut.cnt_q[5]), 32'd0);
    chk("arst_cnt127", 32'(dut.cnt_q[127]), 32'd0);
    step();
    rst = 1'b0;
    in_ctx = 7'd5;
    #1 chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    step();
    chk("post_rst_out_vld", 32'(out_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
